// File: rtl/crop_scheduler.sv
// ============================================================================
// crop_scheduler: per-image random-crop sequencer; advances the external crop
// LFSR, latches a scale code and streams raster-order window read addresses.
// Revision: 1.0
// ============================================================================
`default_nettype none

module crop_scheduler #(
    parameter int IMG_DIM = 28,
    parameter int STEP    = 2,
    parameter int ADDR_W  = 10
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic                         cfg_fixed_en,
    input  logic [1:0]                   cfg_fixed_scale,
    output logic                         lfsr_enable,
    input  logic [1:0]                   lfsr_scale,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(IMG_DIM+1)-1:0] crop_side,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [ADDR_W-1:0]            rd_addr,
    output logic                         rd_last
);

    localparam int                 SIDE_W = $clog2(IMG_DIM + 1);
    localparam logic [ADDR_W-1:0]  DIM_A  = ADDR_W'(IMG_DIM);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADVANCE = 3'd1,
        S_LATCH   = 3'd2,
        S_SCAN    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          scale_q, scale_d;
    logic [SIDE_W-1:0]   side_q, side_d;
    logic [SIDE_W-1:0]   row_q, row_d;
    logic [SIDE_W-1:0]   col_q, col_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                last_q, last_d;
    logic [1:0]          sel_scale;
    logic [ADDR_W-1:0]   off_d;

    function automatic logic [SIDE_W-1:0] side_of(input logic [1:0] s);
        return SIDE_W'(IMG_DIM - 2 * STEP * int'(s));
    endfunction

    function automatic logic [ADDR_W-1:0] off_of(input logic [1:0] s);
        return ADDR_W'(STEP * int'(s));
    endfunction

    assign sel_scale = cfg_fixed_en ? cfg_fixed_scale : lfsr_scale;

    always_comb begin
        state_d = state_q;
        scale_d = scale_q;
        side_d  = side_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_ADVANCE;
            end
            S_ADVANCE: begin
                state_d = abort ? S_IDLE : S_LATCH;
            end
            S_LATCH: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    scale_d = sel_scale;
                    side_d  = side_of(sel_scale);
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                // abort wins over a coincident handshake, including the last one
                if (abort) begin
                    state_d = S_IDLE;
                end else if (rd_ready) begin
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (col_q == side_q - SIDE_W'(1)) begin
                        col_d = '0;
                        row_d = row_q + SIDE_W'(1);
                    end else begin
                        col_d = col_q + SIDE_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Address and last flag are precomputed from next-state counters so the
        // registered outputs line up with the current handshake slot.
        off_d  = off_of(scale_d);
        addr_d = (off_d + ADDR_W'(row_d)) * DIM_A + off_d + ADDR_W'(col_d);
        last_d = (state_d == S_SCAN) &&
                 (row_d == side_d - SIDE_W'(1)) &&
                 (col_d == side_d - SIDE_W'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            scale_q <= '0;
            side_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            addr_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            scale_q <= scale_d;
            side_q  <= side_d;
            row_q   <= row_d;
            col_q   <= col_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end

    assign lfsr_enable = (state_q == S_ADVANCE);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign rd_valid    = (state_q == S_SCAN);
    assign rd_addr     = addr_q;
    assign rd_last     = last_q;
    assign crop_side   = side_q;

endmodule

`default_nettype wire

// File: tb/tb_crop_scheduler.sv
// ============================================================================
// tb_crop_scheduler: randomized self-checking bench with an external LFSR
// model and a raster-order window address reference.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_crop_scheduler;

    localparam int IMG_DIM = 28;
    localparam int STEP    = 2;
    localparam int ADDR_W  = 10;
    localparam int SW      = $clog2(IMG_DIM + 1);
    localparam logic [9:0] LFSR_SEED = 10'b0000101001;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic              cfg_fixed_en;
    logic [1:0]        cfg_fixed_scale;
    logic              lfsr_enable;
    logic [1:0]        lfsr_scale;
    logic              busy;
    logic              done;
    logic [SW-1:0]     crop_side;
    logic              rd_valid;
    logic              rd_ready;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_last;

    int vectors = 0;
    int errors  = 0;
    int adv_count = 0;
    int lfsr_pulses = 0;
    logic [9:0] lfsr_q = LFSR_SEED;

    crop_scheduler #(.IMG_DIM(IMG_DIM), .STEP(STEP), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_fixed_en(cfg_fixed_en), .cfg_fixed_scale(cfg_fixed_scale),
        .lfsr_enable(lfsr_enable), .lfsr_scale(lfsr_scale),
        .busy(busy), .done(done), .crop_side(crop_side),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_last(rd_last)
    );

    always #5 clk = ~clk;

    // External crop LFSR (x^10 + x^7 + 1)
    assign lfsr_scale = lfsr_q[1:0];
    always @(posedge clk) begin
        if (lfsr_enable) begin
            lfsr_q      <= {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
            lfsr_pulses <= lfsr_pulses + 1;
        end
    end

    function automatic int lfsr_scale_after(input int n);
        logic [9:0] v;
        v = LFSR_SEED;
        for (int i = 0; i < n; i++) v = {v[8:0], v[9] ^ v[6]};
        return int'(v[1:0]);
    endfunction

    task automatic run_image(input bit fixed, input int sc_in, input int ready_pct,
                             input int abort_at, input bit poke_start);
        int sc, side, off, n, hs, c, pulses, first_c;
        int exp_q[$];
        bit got_done, aborted;
        adv_count++;
        sc   = fixed ? sc_in : lfsr_scale_after(adv_count);
        side = IMG_DIM - 2 * STEP * sc;
        off  = STEP * sc;
        n    = side * side;
        for (int r = 0; r < side; r++)
            for (int k = 0; k < side; k++)
                exp_q.push_back((off + r) * IMG_DIM + off + k);
        @(negedge clk);
        cfg_fixed_en    = fixed;
        cfg_fixed_scale = sc_in[1:0];
        start = 1'b1; abort = 1'b0; rd_ready = 1'b0;
        c = 0; hs = 0; pulses = 0; first_c = -1; got_done = 0; aborted = 0;
        while (!got_done && !aborted && c < 10 * n + 100) begin
            @(negedge clk);
            c++;
            start    = poke_start && (c == 2 || c == 5 || c == 40);
            abort    = 1'b0;
            rd_ready = 1'b0;
            if (lfsr_enable) begin
                pulses++;
                vectors++;
                if (c !== 1) begin
                    errors++;
                    $display("FAIL lfsr_enable_cycle: seen at cycle %0d, required cycle 1", c);
                end
            end
            if (done) begin
                got_done = 1;
                vectors++;
                if (hs !== n) begin
                    errors++;
                    $display("FAIL handshake_count: got %0d, required %0d", hs, n);
                end
                if (ready_pct == 100) begin
                    vectors++;
                    if (c !== 3 + n) begin
                        errors++;
                        $display("FAIL done_cycle: got %0d, required %0d", c, 3 + n);
                    end
                end
            end else if (rd_valid) begin
                if (first_c < 0) begin
                    first_c = c;
                    vectors += 2;
                    if (c !== 3) begin
                        errors++;
                        $display("FAIL first_valid_cycle: got %0d, required 3", c);
                    end
                    if (crop_side !== side) begin
                        errors++;
                        $display("FAIL crop_side: got %0d, required %0d (scale %0d)", crop_side, side, sc);
                    end
                end
                vectors++;
                if (hs >= n) begin
                    errors++;
                    $display("FAIL addr_overrun: valid at handshake %0d, required max %0d", hs, n);
                end else if (rd_addr !== exp_q[hs][ADDR_W-1:0] || rd_last !== (hs == n - 1)) begin
                    errors++;
                    $display("FAIL rd_addr[%0d]: got addr %0d last %0b, required addr %0d last %0b",
                             hs, rd_addr, rd_last, exp_q[hs], (hs == n - 1));
                end
                rd_ready = ($urandom_range(99) < ready_pct);
                if (hs == abort_at) begin
                    abort   = 1'b1;
                    aborted = 1;
                end else if (rd_ready) begin
                    hs++;
                end
            end
        end
        start = 1'b0;
        if (aborted) begin
            @(negedge clk);
            abort = 1'b0; rd_ready = 1'b0;
            vectors += 2;
            if (rd_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL abort_exit: valid %0b busy %0b done %0b, required 0 0 0", rd_valid, busy, done);
            end
            if (crop_side !== side) begin
                errors++;
                $display("FAIL abort_crop_side: got %0d, required %0d", crop_side, side);
            end
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                vectors++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_quiet: done %0b busy %0b, required 0 0", done, busy);
                end
            end
        end else begin
            vectors++;
            if (!got_done) begin
                errors++;
                $display("FAIL done_timeout: no done after %0d cycles, required done", c);
            end
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL post_done: busy %0b done %0b, required 0 0", busy, done);
            end
        end
        vectors++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL lfsr_pulses_per_image: got %0d, required 1", pulses);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
        cfg_fixed_en = 1'b0; cfg_fixed_scale = 2'd0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({lfsr_enable, busy, done, rd_valid, rd_last} !== 5'b0 || rd_addr !== '0 || crop_side !== '0) begin
            errors++;
            $display("FAIL reset_state: en/busy/done/valid/last=%b addr %0d side %0d, required all 0",
                     {lfsr_enable, busy, done, rd_valid, rd_last}, rd_addr, crop_side);
        end
        reset = 1'b1;
    endtask

    task automatic test_fixed_scale0();   run_image(1, 0, 100, -1, 0); endtask
    task automatic test_fixed_scale3();   run_image(1, 3, 100, -1, 0); endtask
    task automatic test_backpressure();   run_image(1, 1, 50, -1, 0);  endtask
    task automatic test_start_while_busy(); run_image(1, 3, 100, -1, 1); endtask

    task automatic test_lfsr_back_to_back();
        int p0;
        p0 = lfsr_pulses;
        for (int i = 0; i < 5; i++) run_image(0, 0, 100, -1, 0);
        vectors++;
        if (lfsr_pulses - p0 !== 5) begin
            errors++;
            $display("FAIL lfsr_total_pulses: got %0d, required 5", lfsr_pulses - p0);
        end
    endtask

    task automatic test_abort();
        run_image(1, 2, 100, 100, 0);
        run_image(1, 2, 70, -1, 0);
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        cfg_fixed_en = 1'b1; cfg_fixed_scale = 2'd0; start = 1'b1; rd_ready = 1'b1;
        adv_count++;
        @(negedge clk);
        start = 1'b0;
        repeat (50) @(negedge clk);
        vectors++;
        if (rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_scan_valid: got %0b, required 1", rd_valid);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({lfsr_enable, busy, done, rd_valid, rd_last} !== 5'b0 || rd_addr !== '0 || crop_side !== '0) begin
            errors++;
            $display("FAIL reset_mid_scan: en/busy/done/valid/last=%b addr %0d side %0d, required all 0",
                     {lfsr_enable, busy, done, rd_valid, rd_last}, rd_addr, crop_side);
        end
        @(negedge clk);
        rd_ready = 1'b0;
        reset = 1'b1;
        run_image(0, 0, 100, -1, 0);
    endtask

    initial begin
        test_reset();
        test_fixed_scale0();
        test_fixed_scale3();
        test_lfsr_back_to_back();
        test_backpressure();
        test_abort();
        test_start_while_busy();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/crop_scheduler.md
Name: crop_scheduler

Overview:
- Per-image sequencer for the random crop/rescale augmentation stage.
- On each image start it advances the crop LFSR exactly once and latches the 2-bit scale code.
- It derives a centred square crop window from that code, then streams source-buffer read addresses for the window in raster order over a valid/ready handshake.
- It sits between the image-buffer read port and the rescale datapath; the LFSR instance is external and driven through lfsr_enable / lfsr_scale.

Parameters:
- IMG_DIM, 28, source image side length in pixels (square image).
- STEP, 2, crop shrink per scale unit per side. Crop side = IMG_DIM - 2*STEP*scale; offset = STEP*scale. Legal only if IMG_DIM - 6*STEP >= 1.
- ADDR_W, 10, read address width. Must satisfy 2^ADDR_W >= IMG_DIM*IMG_DIM.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin one image; sampled only in IDLE.
- abort  input  1  cancel current image; returns to IDLE.
- cfg_fixed_en  input  1  use cfg_fixed_scale instead of lfsr_scale (evaluation mode).
- cfg_fixed_scale  input  2  override scale code.
- lfsr_enable  output  1  one-cycle advance pulse to the external crop LFSR.
- lfsr_scale  input  2  current LFSR scale output.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse after the last address handshake.
- crop_side  output  $clog2(IMG_DIM+1)  latched crop side for the rescale stage; valid from SCAN entry until the next LATCH.
- rd_valid  output  1  rd_addr valid.
- rd_ready  input  1  consumer accepts rd_addr.
- rd_addr  output  ADDR_W  (off+row)*IMG_DIM + (off+col).
- rd_last  output  1  high with the final address of the window.

Behaviour:
- Reset values (reset low): state IDLE; lfsr_enable, busy, done, rd_valid, rd_last = 0; rd_addr, crop_side, scale register, row, col = 0.
- FSM states: IDLE, ADVANCE, LATCH, SCAN, DONE.
- IDLE: start=1 -> ADVANCE. start in any other state is ignored (no queuing).
- ADVANCE: lfsr_enable=1 for exactly this cycle -> LATCH. The LFSR updates on the edge ending ADVANCE.
- LATCH: at the end of the cycle, capture scale = cfg_fixed_en ? cfg_fixed_scale : lfsr_scale. Also compute crop_side and offset; clear row and col -> SCAN.
- lfsr_enable is asserted in ADVANCE only, including when cfg_fixed_en=1, so the LFSR sequence stays aligned to the image count.
- SCAN:
  - rd_valid=1. rd_addr and rd_last are registered functions of row, col and offset, and are stable while rd_ready=0.
  - On rd_valid&&rd_ready: col increments. At col==side-1, col wraps to 0 and row increments.
  - rd_last = (row==side-1)&&(col==side-1).
  - A handshake with rd_last=1 -> DONE.
- DONE: done=1 for one cycle -> IDLE. busy drops in the following cycle.
- Latency: start at cycle 0 -> lfsr_enable at cycle 1 -> first rd_valid at cycle 3. With rd_ready tied high, done pulses at cycle 3+side^2.
- Total handshakes per image = side^2; addresses are strictly increasing.
- abort=1 in ADVANCE, LATCH or SCAN:
  - next state IDLE, rd_valid drops the next cycle, no done pulse;
  - crop_side holds its last value;
  - an abort during ADVANCE still counts the LFSR advance.
- abort in DONE is ignored (done still pulses). abort has priority over a simultaneous final handshake.
- reset asserted mid-operation clears everything immediately (asynchronous). No partial handshake is completed.
- Address arithmetic: (off+row)*IMG_DIM + off+col is computed unsigned, with no truncation under the parameter constraints.

Test Plan:
- cfg_fixed_en=1, scale 0, rd_ready=1, start pulse:
  - one lfsr_enable pulse;
  - crop_side=28;
  - 784 handshakes, addresses 0..783 consecutive;
  - rd_last only on 783;
  - done at cycle 787.
- Fixed scale 3:
  - crop_side=16;
  - first addr 174, second 175, 17th addr 202 (row wrap);
  - last addr 609 with rd_last;
  - 256 handshakes.
- LFSR mode, model external LFSR (reset value 10'b0000101001) in the bench:
  - latched scale equals the model's d[1:0] after one advance;
  - across 5 back-to-back images, exactly 5 lfsr_enable pulses.
- Backpressure with random rd_ready (~50%), fixed scale 1:
  - rd_addr/rd_last held stable while stalled;
  - address sequence identical to the no-stall run (first 58, last 8 wraps to row 23: 25*28+25=725).
- abort at handshake 100 of a scale-2 image:
  - rd_valid low next cycle, no done, busy low;
  - a following start runs a full image correctly.
- start pulsed while busy is ignored (single image only).
- reset low mid-SCAN: all outputs 0 immediately, state IDLE.
